// File: rtl/seq_detector_pkg.sv
// -----------------------------------------------------------------------------
// seq_detector_pkg
// Shared definitions for the parameterised serial sequence detector:
//   - state_e    : detector FSM states (S_FILL while collecting bits,
//                  S_ARMED once enough bits are held to compare every cycle)
//   - PAT_W_DEF  : default maximum pattern length in bits
//   - CNT_W_DEF  : default match-counter width
//   - len_legal(): a pattern length is usable only when 1 <= len <= pat_w
// -----------------------------------------------------------------------------
package seq_detector_pkg;

    localparam int unsigned PAT_W_DEF = 32'd8;
    localparam int unsigned CNT_W_DEF = 32'd16;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_e;

    // A zero length or a length wider than the history makes the detector idle
    function automatic logic len_legal(input logic [31:0] len, input logic [31:0] pat_w);
        len_legal = (len != 32'd0) && (len <= pat_w);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// -----------------------------------------------------------------------------
// seq_match_counter
// Saturating up-counter for detected matches; sticks at all-ones instead of
// wrapping.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset (count -> 0)
//   clr    in  synchronous clear, dominates inc
//   inc    in  add one this cycle (ignored once saturated)
//   count  out registered count, CNT_W bits
// -----------------------------------------------------------------------------
module seq_match_counter #(
    parameter int unsigned CNT_W = 32'd16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise saturating increment
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Serial bit-pattern detector with a runtime-programmable pattern (up to PAT_W
// bits, bit 0 = most recent bit), runtime length and overlap mode. A match
// produces a one-cycle 'detected' pulse one cycle after the completing valid
// bit.
//
// Build option: define SEQ_DETECTOR_COUNT_EN to include the saturating match
// counter; without it match_count is tied to zero and no counter is built.
//
// Ports:
//   clk         in  rising-edge clock
//   reset       in  asynchronous active-low reset
//   in_valid    in  in_bit is sampled this cycle
//   in_bit      in  serial data bit
//   cfg_load    in  latch pattern/pat_len/overlap and restart detection
//   pattern     in  target pattern [PAT_W-1:0]
//   pat_len     in  active length [LEN_W-1:0]; 0 or >PAT_W disables matching
//   overlap     in  1 = matches may share bits
//   clear       in  synchronous flush of history, fill and counter
//   detected    out one-cycle match pulse (registered)
//   armed       out FSM is in S_ARMED
//   match_count out saturating match count [CNT_W-1:0]
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned LEN_W = $clog2(PAT_W + 32'd1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             clear,
    output logic             detected,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
);

    // Only the PAT_W-1 newest bits are stored: after a shift the oldest bit
    // would fall straight off, so the post-shift window is {hist_q, in_bit}.
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             ovl_q, ovl_d;
    logic             det_q, det_d;
    state_e           state_q, state_d;

    logic [PAT_W-1:0] hist_shift_s;
    logic [PAT_W:0]   mask_wide_s;
    logic [PAT_W-1:0] mask_s;
    logic [LEN_W-1:0] fill_inc_s;
    logic             en_s;
    logic             full_s;
    logic             match_s;
    logic             hit_s;

    // Match evaluation on the post-shift window
    always_comb begin
        en_s         = len_legal(32'(len_q), 32'(PAT_W));
        hist_shift_s = {hist_q, in_bit};
        // Low len_q ones; computed one bit wider so len_q == PAT_W works
        mask_wide_s  = ({{PAT_W{1'b0}}, 1'b1} << len_q) - {{PAT_W{1'b0}}, 1'b1};
        mask_s       = mask_wide_s[PAT_W-1:0];
        if (fill_q < len_q) begin
            fill_inc_s = fill_q + LEN_W'(1'b1);
        end else begin
            fill_inc_s = fill_q;
        end
        full_s  = (fill_inc_s >= len_q);
        match_s = in_valid && en_s && full_s &&
                  ((hist_shift_s & mask_s) == (pat_q & mask_s));
        // A bit arriving together with clear or cfg_load is discarded
        hit_s   = match_s && !clear && !cfg_load;
    end

    // Datapath next-state: config, history and fill counter
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = {(PAT_W-1){1'b0}};
            fill_d = {LEN_W{1'b0}};
        end else if (cfg_load) begin
            pat_d  = pattern;
            len_d  = pat_len;
            ovl_d  = overlap;
            hist_d = {(PAT_W-1){1'b0}};
            fill_d = {LEN_W{1'b0}};
        end else if (in_valid) begin
            hist_d = hist_shift_s[PAT_W-2:0];
            if (!en_s) begin
                fill_d = {LEN_W{1'b0}};
            end else if (hit_s && !ovl_q) begin
                // Non-overlapping: the next match needs a fresh len_q bits
                fill_d = {LEN_W{1'b0}};
            end else begin
                fill_d = fill_inc_s;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
    end

    // FSM next-state and detect pulse
    always_comb begin
        state_d = state_q;
        det_d   = hit_s;
        case (state_q)
            S_FILL: begin
                if (!clear && !cfg_load && in_valid && en_s && full_s &&
                    !(hit_s && !ovl_q)) begin
                    state_d = S_ARMED;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_ARMED: begin
                if (clear || cfg_load || (hit_s && !ovl_q) || (in_valid && !en_s)) begin
                    state_d = S_FILL;
                end else begin
                    state_d = S_ARMED;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State, configuration and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q   <= {PAT_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            ovl_q   <= 1'b0;
            hist_q  <= {(PAT_W-1){1'b0}};
            fill_q  <= {LEN_W{1'b0}};
            det_q   <= 1'b0;
            state_q <= S_FILL;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            det_q   <= det_d;
            state_q <= state_d;
        end
    end

    assign detected = det_q;
    assign armed    = (state_q == S_ARMED);

`ifdef SEQ_DETECTOR_COUNT_EN
    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (hit_s),
        .count (match_count)
    );
`else
    assign match_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int CLK_P = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_bit, cfg_load, overlap, clear;
    logic [7:0]  pattern;
    logic [3:0]  pat_len;
    logic        detected, armed;
    logic [15:0] match_count;
    logic        det_s, armed_s;
    logic [1:0]  cnt_s;

    always #(CLK_P/2) clk = ~clk;

    seq_detector_param #(.PAT_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
        .overlap(overlap), .clear(clear), .detected(detected),
        .armed(armed), .match_count(match_count)
    );

    seq_detector_param #(.PAT_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
        .overlap(overlap), .clear(clear), .detected(det_s),
        .armed(armed_s), .match_count(cnt_s)
    );

    typedef struct {
        time         due;
        logic        det;
        logic        arm;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   dut_pulses = 0;

    // Reference model: config plus the list of bits received since last restart
    logic [7:0] m_pat = 8'd0;
    int         m_len = 0;
    logic       m_ovl = 1'b0;
    bit         m_recent[$];
    longint     m_cnt = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit model_en();
        return (m_len >= 1) && (m_len <= 8);
    endfunction

    function automatic bit model_match();
        int sz;
        sz = m_recent.size();
        if (!model_en() || sz < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (m_recent[sz-1-i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input logic v, input logic b, input logic cfg,
                              input logic clr, output logic det);
        det = 1'b0;
        if (clr) begin
            m_recent.delete();
            m_cnt = 0;
        end else if (cfg) begin
            m_pat = pattern;
            m_len = int'(pat_len);
            m_ovl = overlap;
            m_recent.delete();
        end else if (v) begin
            m_recent.push_back(b);
            if (m_recent.size() > 32) void'(m_recent.pop_front());
            if (model_match()) begin
                det = 1'b1;
                m_cnt++;
                if (!m_ovl) m_recent.delete();
            end
        end
    endtask

    task automatic model_reset();
        m_pat = 8'd0;
        m_len = 0;
        m_ovl = 1'b0;
        m_recent.delete();
        m_cnt = 0;
    endtask

    // One stimulus cycle: drive, advance the model, queue the expected outputs
    task automatic cycle(input logic v, input logic b, input logic cfg, input logic clr);
        exp_t e;
        logic d;
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        cfg_load = cfg;
        clear    = clr;
        model_step(v, b, cfg, clr, d);
        e.due = $time + CLK_P;
        e.det = d;
        e.arm = model_en() && (m_recent.size() >= m_len);
`ifdef SEQ_DETECTOR_COUNT_EN
        e.cnt  = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        e.cnt2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
`else
        e.cnt  = 16'd0;
        e.cnt2 = 2'd0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        pattern = pat;
        pat_len = len;
        overlap = ovl;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Bits are sent oldest first from bits[n-1] down to bits[0]
    task automatic send(input logic [31:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            cycle(1'b1, bits[i], 1'b0, 1'b0);
            repeat (gap) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        cmp("drain", exp_q.size(), 0);
    endtask

    task automatic expect_pulses(input string name, input int p0, input int want);
        drain();
        cmp(name, dut_pulses - p0, want);
    endtask

    // Monitor: compare DUT outputs against due scoreboard entries
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (detected === 1'b1) dut_pulses++;
            if (exp_q.size() > 0 && exp_q[0].due <= $time) begin
                e = exp_q.pop_front();
                cmp("detected", detected, e.det);
                cmp("armed", armed, e.arm);
                cmp("match_count", match_count, e.cnt);
                cmp("match_count_sat", cnt_s, e.cnt2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int r;
        reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
        clear = 1'b0; overlap = 1'b0; pattern = 8'd0; pat_len = 4'd0;
        #12;
        cmp("reset_detected", detected, 0);
        cmp("reset_armed", armed, 0);
        cmp("reset_count", match_count, 0);
        @(negedge clk);
        reset = 1'b1;

        // Pattern 11, overlap: pulses after bits 4 and 7
        p0 = dut_pulses;
        configure(8'b11, 4'd2, 1'b1);
        send(32'b0011011, 7, 0);
        expect_pulses("pulses_11_stream", p0, 2);

        // 1,1,1 with overlap / without overlap
        p0 = dut_pulses;
        configure(8'b11, 4'd2, 1'b1);
        send(32'b111, 3, 0);
        expect_pulses("pulses_111_ovl", p0, 2);
        p0 = dut_pulses;
        configure(8'b11, 4'd2, 1'b0);
        send(32'b111, 3, 0);
        expect_pulses("pulses_111_noovl", p0, 1);

        // 1011 stream, both overlap modes, then with 3 idle cycles between bits
        p0 = dut_pulses;
        configure(8'b1011, 4'd4, 1'b1);
        send(32'b1011011, 7, 0);
        expect_pulses("pulses_1011_ovl", p0, 2);
        p0 = dut_pulses;
        configure(8'b1011, 4'd4, 1'b0);
        send(32'b1011011, 7, 0);
        expect_pulses("pulses_1011_noovl", p0, 1);
        p0 = dut_pulses;
        configure(8'b1011, 4'd4, 1'b1);
        send(32'b1011011, 7, 3);
        expect_pulses("pulses_1011_gaps", p0, 2);

        // Saturation on the narrow counter, then clear with a valid bit
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        p0 = dut_pulses;
        configure(8'b11, 4'd2, 1'b1);
        send(32'b111111, 6, 0);
        expect_pulses("pulses_sat", p0, 5);
        p0 = dut_pulses;
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        expect_pulses("pulses_clear_valid", p0, 0);

        // Asynchronous reset while armed and mid-pattern
        configure(8'b1011, 4'd4, 1'b1);
        send(32'b101101, 6, 0);
        drain();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        cmp("async_detected", detected, 0);
        cmp("async_armed", armed, 0);
        cmp("async_count", match_count, 0);
        cmp("async_count_sat", cnt_s, 0);
        @(negedge clk);
        reset = 1'b1;
        p0 = dut_pulses;
        send(32'b1, 1, 0);
        expect_pulses("pulses_after_reset", p0, 0);

        // Zero length never matches
        p0 = dut_pulses;
        configure(8'b0, 4'd0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        send(32'd0, 8, 0);
        expect_pulses("pulses_len0", p0, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                pattern = 8'($urandom);
                pat_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 10))
                                                      : 4'($urandom_range(1, 4));
                overlap = 1'($urandom_range(0, 1));
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            end else if (r < 4) begin
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b1);
            end else begin
                cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 8, meaning maximum pattern length in bits (legal 2..32).
REQ-002 SHALL have parameter CNT_W, default 16, meaning match-counter width.
REQ-003 SHALL have parameter LEN_W, default $clog2(PAT_W+1), meaning width of the pattern-length field.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, meaning the reset; it is asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning in_bit is sampled this cycle.
REQ-007 SHALL have port in_bit, input, 1, meaning the serial data bit.
REQ-008 SHALL have port cfg_load, input, 1, meaning latch pattern/pat_len/overlap this cycle.
REQ-009 SHALL have port pattern, input, PAT_W, meaning the target pattern; bit 0 is the most recent bit.
REQ-010 SHALL have port pat_len, input, LEN_W, meaning the active pattern length.
REQ-011 SHALL have port overlap, input, 1, meaning 1 = overlapping matches allowed.
REQ-012 SHALL have port clear, input, 1, meaning synchronous flush of history, fill and counter.
REQ-013 SHALL have port detected, output, 1, meaning a one-cycle match pulse.
REQ-014 SHALL have port armed, output, 1, meaning the FSM is in S_ARMED.
REQ-015 SHALL have port match_count, output, CNT_W, meaning the saturating match count.

Function
REQ-016 SHALL keep internal config registers (pat_q, len_q, ovl_q), loaded only on cfg_load; the ports are ignored otherwise.
REQ-017 SHALL shift the history register on in_valid: hist <= {hist[PAT_W-2:0], in_bit}; no shift when in_valid=0.
REQ-018 SHALL track fill_cnt, the number of valid bits since the last restart, saturating at len_q.
REQ-019 SHALL implement FSM S_FILL -> S_ARMED when a valid bit makes fill_cnt reach len_q; S_ARMED -> S_FILL on non-overlap match, cfg_load or clear.
REQ-020 SHALL declare a match on a valid cycle when the post-shift hist[len_q-1:0] equals pat_q[len_q-1:0] and fill_cnt (including this bit) >= len_q.
REQ-021 SHALL register detected, asserting it exactly one cycle after the completing in_valid cycle (latency 1) for one cycle per match.
REQ-022 SHALL reset fill_cnt to 0 on a match when ovl_q=0; when ovl_q=1 fill_cnt stays saturated.
REQ-023 SHALL treat len_q=0 or len_q>PAT_W as disabled: detected=0, armed=0, and history still shifts.
REQ-024 SHALL restart on cfg_load: fill_cnt=0, history zeroed, state S_FILL, counter kept; a bit valid in the same cycle is discarded.
REQ-025 SHALL give clear priority over cfg_load and in_valid in the same cycle, zeroing history, fill_cnt and match_count and entering S_FILL; config registers are kept.
REQ-026 SHALL increment match_count by 1 per match and hold it at 2^CNT_W-1 (no wrap).

Reset
REQ-027 SHALL, on reset low, immediately set detected=0, armed=0, match_count=0, hist=0, fill_cnt=0, state=S_FILL, pat_q=0, len_q=0 (disabled) and ovl_q=0.
REQ-028 SHALL ignore inputs while reset is low; reset is asserted asynchronously and released synchronously by the integrating design.

Configuration
REQ-029 SHALL compile the counter in when SEQ_DETECTOR_COUNT_EN is defined: match_count operates per REQ-026.
REQ-030 SHALL, when SEQ_DETECTOR_COUNT_EN is undefined, keep the match_count port, drive it constant 0, and infer no counter flops.

Structure
REQ-031 SHALL place in package seq_detector_pkg: the state enum (S_FILL, S_ARMED), default PAT_W/CNT_W constants, and the len-legality helper function.
REQ-032 SHALL implement the saturating counter as sub-module seq_match_counter (clk, reset, clr, inc, count), instantiated only under SEQ_DETECTOR_COUNT_EN.

Verification
REQ-033 SHALL cover: pattern=2'b11, len=2, overlap=1, bits 0,0,1,1,0,1,1 -> detected after bits 4 and 7, match_count=2.
REQ-034 SHALL cover: pattern=11, len=2, bits 1,1,1 -> overlap=1 gives 2 pulses; overlap=0 gives 1 pulse.
REQ-035 SHALL cover: pattern=4'b1011, len=4, bits 1,0,1,1,0,1,1 -> overlap=1 gives pulses after bits 4 and 7; overlap=0 gives a pulse after bit 4 only.
REQ-036 SHALL cover: in_valid gaps of 3 idle cycles inside the "1011" stream -> same pulses, each one cycle after its completing valid bit.
REQ-037 SHALL cover: CNT_W=2, 5 matches -> match_count saturates at 3; clear with in_valid=1 -> match_count=0, no pulse.
REQ-038 SHALL cover: reset low mid-pattern (after 1,0,1) -> outputs 0 immediately; after release, bits 1 alone give no pulse; len=0 gives no pulses ever.
